// File: rtl/alu.sv
// Multi-cycle ALU that captures its operands and opcode and presents registered results with a DONE flag.
// Define ALU_MUL_EN to build the iterative shift-add multiplier for opcode 0x03; otherwise 0x03 is unsupported.
module alu #(
    parameter int DATA_WIDTH = 32,
    parameter int OPRN_WIDTH = 6
) (
    output logic [DATA_WIDTH-1:0] RH,
    output logic [DATA_WIDTH-1:0] RL,
    output logic                  DONE,
    output logic                  ZERO,
    input  logic [DATA_WIDTH-1:0] OP1,
    input  logic [DATA_WIDTH-1:0] OP2,
    input  logic [OPRN_WIDTH-1:0] OPRN,
    input  logic                  CLK,
    input  logic                  RST
);

    localparam logic [OPRN_WIDTH-1:0] OP_ADD  = OPRN_WIDTH'(1);
    localparam logic [OPRN_WIDTH-1:0] OP_SUB  = OPRN_WIDTH'(2);
    localparam logic [OPRN_WIDTH-1:0] OP_MUL  = OPRN_WIDTH'(3);
    localparam logic [OPRN_WIDTH-1:0] OP_SHL  = OPRN_WIDTH'(4);
    localparam logic [OPRN_WIDTH-1:0] OP_SHR  = OPRN_WIDTH'(5);
    localparam logic [OPRN_WIDTH-1:0] OP_AND  = OPRN_WIDTH'(6);
    localparam logic [OPRN_WIDTH-1:0] OP_OR   = OPRN_WIDTH'(7);
    localparam logic [OPRN_WIDTH-1:0] OP_NOR  = OPRN_WIDTH'(8);
    localparam logic [OPRN_WIDTH-1:0] OP_ADD2 = OPRN_WIDTH'(9);

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;
`else
    typedef enum logic [1:0] {IDLE, EXEC} state_t;
`endif

    state_t                  state;
    logic [DATA_WIDTH-1:0]   op1_q;
    logic [DATA_WIDTH-1:0]   op2_q;
    logic [OPRN_WIDTH-1:0]   oprn_q;
    logic                    pending;
    logic                    capture;
    logic [DATA_WIDTH-1:0]   res_hi;
    logic [DATA_WIDTH-1:0]   res_lo;

    // pending forces a capture on the first edge after reset even if the inputs match the cleared copies
    assign capture = pending || (OP1 != op1_q) || (OP2 != op2_q) || (OPRN != oprn_q);

`ifdef ALU_MUL_EN
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [2*DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0]   mcand;
    logic [CNT_W-1:0]        cnt;
    logic [DATA_WIDTH:0]     mul_sum;
    logic [2*DATA_WIDTH-1:0] prod_next;
    logic                    mul_last;

    // prod holds {partial sum, remaining multiplier bits}; each step adds and shifts right by one
    assign mul_sum   = {1'b0, prod[2*DATA_WIDTH-1:DATA_WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    assign prod_next = {mul_sum, prod[DATA_WIDTH-1:1]};
    assign mul_last  = (cnt == CNT_W'(DATA_WIDTH - 1));
`endif

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        case (oprn_q)
            OP_ADD, OP_ADD2: res_lo = op1_q + op2_q;
            OP_SUB:          res_lo = op1_q - op2_q;
            OP_SHL:          res_lo = op1_q << op2_q;
            OP_SHR:          res_lo = op1_q >> op2_q;
            OP_AND:          res_lo = op1_q & op2_q;
            OP_OR:           res_lo = op1_q | op2_q;
            OP_NOR:          res_lo = ~(op1_q | op2_q);
`ifdef ALU_MUL_EN
            OP_MUL:          {res_hi, res_lo} = prod;
`endif
            default: begin
                res_hi = '0;
                res_lo = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            op1_q   <= '0;
            op2_q   <= '0;
            oprn_q  <= '0;
            pending <= 1'b1;
            RH      <= '0;
            RL      <= '0;
            ZERO    <= 1'b1;
            DONE    <= 1'b0;
`ifdef ALU_MUL_EN
            prod    <= '0;
            mcand   <= '0;
            cnt     <= '0;
`endif
        end else if (capture) begin
            op1_q   <= OP1;
            op2_q   <= OP2;
            oprn_q  <= OPRN;
            pending <= 1'b0;
            DONE    <= 1'b0;
`ifdef ALU_MUL_EN
            cnt     <= '0;
            if (OPRN == OP_MUL) begin
                state <= MUL;
                prod  <= {{DATA_WIDTH{1'b0}}, OP2};
                mcand <= OP1;
            end else begin
                state <= EXEC;
            end
`else
            state   <= EXEC;
`endif
        end else begin
            case (state)
                EXEC: begin
                    RH    <= res_hi;
                    RL    <= res_lo;
                    ZERO  <= ~|{res_hi, res_lo};
                    DONE  <= 1'b1;
                    state <= IDLE;
                end
`ifdef ALU_MUL_EN
                // after the last iteration EXEC writes the finished product out
                MUL: begin
                    prod <= prod_next;
                    if (mul_last) begin
                        cnt   <= '0;
                        state <= EXEC;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu; mul vectors are included when ALU_MUL_EN is defined.
module tb_alu;

    logic [31:0] RH;
    logic [31:0] RL;
    logic        DONE;
    logic        ZERO;
    logic [31:0] OP1;
    logic [31:0] OP2;
    logic [5:0]  OPRN;
    logic        CLK;
    logic        RST;

    int n_assert = 0;
    int n_fail   = 0;

    alu #(.DATA_WIDTH(32), .OPRN_WIDTH(6)) dut (
        .RH(RH), .RL(RL), .DONE(DONE), .ZERO(ZERO),
        .OP1(OP1), .OP2(OP2), .OPRN(OPRN), .CLK(CLK), .RST(RST)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
        OP1  = a;
        OP2  = b;
        OPRN = op;
    endtask

    // single-cycle op: DONE low on the capture edge with the old result held, result on the next edge
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] op, input logic [31:0] exp_lo);
        logic [31:0] prev_lo;
        prev_lo = RL;
        apply(a, b, op);
        tick();
        chk({tag, " done_low"}, 64'(DONE), 64'(1'b0));
        chk({tag, " hold_rl"}, 64'(RL), 64'(prev_lo));
        tick();
        chk({tag, " rl"}, 64'(RL), 64'(exp_lo));
        chk({tag, " rh"}, 64'(RH), 64'h0);
        chk({tag, " zero"}, 64'(ZERO), 64'(exp_lo == 32'h0));
        chk({tag, " done"}, 64'(DONE), 64'(1'b1));
    endtask

`ifdef ALU_MUL_EN
    task automatic wait_mul(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        for (int i = 0; i < 32; i++) begin
            tick();
            chk({tag, " mul_done_low"}, 64'(DONE), 64'(1'b0));
        end
        tick();
        chk({tag, " mul_rh"}, 64'(RH), 64'(exp_hi));
        chk({tag, " mul_rl"}, 64'(RL), 64'(exp_lo));
        chk({tag, " mul_zero"}, 64'(ZERO), 64'({exp_hi, exp_lo} == 64'h0));
        chk({tag, " mul_done"}, 64'(DONE), 64'(1'b1));
    endtask
`endif

    initial begin
        RST = 1'b1;
        apply(32'd15, 32'd3, 6'h01);
        #1;
        chk("rst_rh", 64'(RH), 64'h0);
        chk("rst_rl", 64'(RL), 64'h0);
        chk("rst_zero", 64'(ZERO), 64'h1);
        chk("rst_done", 64'(DONE), 64'h0);
        tick();
        tick();
        chk("rst_hold_done", 64'(DONE), 64'h0);
        RST = 1'b0;

        tick();
        chk("first_capture_done", 64'(DONE), 64'h0);
        tick();
        chk("add_rl", 64'(RL), 64'd18);
        chk("add_rh", 64'(RH), 64'h0);
        chk("add_zero", 64'(ZERO), 64'h0);
        chk("add_done", 64'(DONE), 64'h1);

        run_op("sub",  32'd15, 32'd5, 6'h02, 32'd10);
        run_op("shl",  32'd15, 32'd5, 6'h04, 32'd480);
        run_op("shr",  32'd15, 32'd5, 6'h05, 32'd0);
        run_op("and",  32'd15, 32'd5, 6'h06, 32'd5);
        run_op("or",   32'd15, 32'd5, 6'h07, 32'd15);
        run_op("nor",  32'd15, 32'd5, 6'h08, 32'hFFFF_FFF0);
        run_op("add9", 32'd15, 32'd5, 6'h09, 32'd20);
        run_op("add1", 32'd15, 32'd5, 6'h01, 32'd20);

        run_op("shl31",  32'd1, 32'd31, 6'h04, 32'h8000_0000);
        run_op("shl32",  32'd1, 32'd32, 6'h04, 32'h0);
        run_op("shr31",  32'h8000_0000, 32'd31, 6'h05, 32'h1);
        run_op("shrbig", 32'h8000_0000, 32'hFFFF_FFFF, 6'h05, 32'h0);
        run_op("addwrap", 32'hFFFF_FFFF, 32'd2, 6'h01, 32'h1);
        run_op("subwrap", 32'd0, 32'd1, 6'h02, 32'hFFFF_FFFF);

        run_op("and79", 32'd7, 32'd9, 6'h06, 32'h1);
        run_op("op00",  32'd7, 32'd9, 6'h00, 32'h0);
        run_op("or79",  32'd7, 32'd9, 6'h07, 32'd15);
        run_op("op3f",  32'd7, 32'd9, 6'h3F, 32'h0);
        run_op("and79b", 32'd7, 32'd9, 6'h06, 32'h1);
        run_op("op0a",  32'd7, 32'd9, 6'h0A, 32'h0);
        run_op("sub_eq", 32'd15, 32'd15, 6'h02, 32'h0);

        run_op("hold_or", 32'd15, 32'd5, 6'h07, 32'd15);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_done", 64'(DONE), 64'h1);
            chk("idle_rl", 64'(RL), 64'd15);
        end

        // change inputs while a single-cycle op is pending; only the new result may appear
        apply(32'd4, 32'd4, 6'h01);
        tick();
        chk("abort_exec_done0", 64'(DONE), 64'h0);
        apply(32'd4, 32'd6, 6'h01);
        tick();
        chk("abort_exec_done1", 64'(DONE), 64'h0);
        chk("abort_exec_hold", 64'(RL), 64'd15);
        tick();
        chk("abort_exec_rl", 64'(RL), 64'd10);
        chk("abort_exec_done", 64'(DONE), 64'h1);

        apply(32'd100, 32'd23, 6'h02);
        tick();
        chk("rst_mid_capture", 64'(DONE), 64'h0);
        #2;
        RST = 1'b1;
        #1;
        chk("rst_mid_rh", 64'(RH), 64'h0);
        chk("rst_mid_rl", 64'(RL), 64'h0);
        chk("rst_mid_zero", 64'(ZERO), 64'h1);
        chk("rst_mid_done", 64'(DONE), 64'h0);
        tick();
        RST = 1'b0;
        tick();
        chk("rst_rel_capture", 64'(DONE), 64'h0);
        tick();
        chk("rst_rel_rl", 64'(RL), 64'd77);
        chk("rst_rel_done", 64'(DONE), 64'h1);

`ifdef ALU_MUL_EN
        apply(32'd15, 32'd5, 6'h03);
        tick();
        chk("mul_capture", 64'(DONE), 64'h0);
        wait_mul("m15x5", 32'h0, 32'd75);

        apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'h03);
        tick();
        wait_mul("mffff", 32'hFFFF_FFFE, 32'h0000_0001);

        apply(32'd15, 32'd5, 6'h03);
        tick();
        for (int i = 0; i < 10; i++) tick();
        chk("mul_mid_done", 64'(DONE), 64'h0);
        apply(32'd15, 32'd7, 6'h03);
        tick();
        wait_mul("mchg", 32'h0, 32'd105);

        apply(32'd6, 32'd9, 6'h03);
        tick();
        for (int i = 0; i < 5; i++) tick();
        #2;
        RST = 1'b1;
        #1;
        chk("mul_rst_rl", 64'(RL), 64'h0);
        chk("mul_rst_zero", 64'(ZERO), 64'h1);
        chk("mul_rst_done", 64'(DONE), 64'h0);
        tick();
        RST = 1'b0;
        tick();
        wait_mul("mrst", 32'h0, 32'd54);
`else
        run_op("mul_off", 32'd15, 32'd5, 6'h03, 32'h0);
        chk("mul_off_zero", 64'(ZERO), 64'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
